// File: rtl/resp_frame_tx_pkg.sv
// resp_tx_pkg: shared state encoding and defaults for the response framer
package resp_tx_pkg;
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SEND  = 3'd1,
    S_WAIT  = 3'd2,
    S_DONE  = 3'd3,
    S_REARM = 3'd4
  } state_t;
  localparam int DATA_W_DEF = 8;
endpackage

// File: rtl/resp_frame_tx_if.sv
// resp_frame_tx_if: word handshake between the framer and uart_tx
interface resp_frame_tx_if import resp_tx_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF
) ();
  logic [DATA_W-1:0] tx_data;
  logic              tx_start;
  logic              tx_done;
  modport master (output tx_data, output tx_start, input tx_done);
  modport slave  (input tx_data, input tx_start, output tx_done);
endinterface

// File: rtl/resp_frame_tx_watchdog.sv
// tx_watchdog: counts cycles spent waiting for tx_done, flags the terminal count
module tx_watchdog #(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);
  generate
    if (TIMEOUT == 0) begin : g_off
      logic unused_wd;
      assign unused_wd = ^{clk, rst, clr, en};
      assign expired = 1'b0;
    end else begin : g_on
      localparam int CW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
      logic [CW-1:0] cnt;
      always_ff @(posedge clk or negedge rst)
        if (!rst) cnt <= '0;
        else if (clr) cnt <= '0;
        else if (en) cnt <= cnt + 1'b1;
      assign expired = en && cnt == CW'(TIMEOUT - 1);
    end
  endgenerate
endmodule

// File: rtl/resp_frame_tx.sv
// resp_frame_tx: sends a header plus up to MAX_BYTES payload words once all sources are done
module resp_frame_tx import resp_tx_pkg::*; #(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int MAX_BYTES = 4,
  parameter int NUM_SRC   = 2,
  parameter int TIMEOUT   = 1024,
  parameter int LEN_W     = $clog2(MAX_BYTES + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_SRC-1:0]        src_done,
  input  logic [DATA_W-1:0]         hdr,
  input  logic [MAX_BYTES*DATA_W-1:0] payload,
  input  logic [LEN_W-1:0]          payload_len,
  input  logic                      stream_en,
  input  logic                      cnt_en_in,
  resp_frame_tx_if.master           tx,
  output logic                      busy,
  output logic                      frame_done,
  output logic                      cnt_en,
  output logic                      tx_err
);
  state_t st, st_n;
  logic [DATA_W-1:0] frm_q [MAX_BYTES+1];
  logic [DATA_W-1:0] frm_n [MAX_BYTES+1];
  logic [LEN_W-1:0] len_q, len_n, idx_q, idx_n;
  logic [DATA_W-1:0] data_n;
  logic start_n, busy_n, fd_n, cnt_n, err_n, wd_clr, wd_en, wd_exp, trig;
  assign trig = &src_done;
  tx_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
    .clk(clk), .rst(rst), .clr(wd_clr), .en(wd_en), .expired(wd_exp)
  );
  // frame slot 0 is the header, slots 1..MAX_BYTES the payload words
  always_comb begin
    st_n = st;
    frm_n = frm_q;
    len_n = len_q;
    idx_n = idx_q;
    data_n = tx.tx_data;
    start_n = 1'b0;
    busy_n = busy;
    fd_n = 1'b0;
    cnt_n = cnt_en;
    err_n = 1'b0;
    wd_clr = 1'b0;
    wd_en = 1'b0;
    case (st)
      S_IDLE: if (trig) begin
        frm_n[0] = hdr;
        for (int i = 0; i < MAX_BYTES; i++) frm_n[i+1] = payload[i*DATA_W +: DATA_W];
        len_n = payload_len > LEN_W'(MAX_BYTES) ? LEN_W'(MAX_BYTES) : payload_len;
        busy_n = 1'b1;
        st_n = S_SEND;
      end
      S_SEND: begin
        data_n = frm_q[idx_q];
        start_n = 1'b1;
        wd_clr = 1'b1;
        st_n = S_WAIT;
      end
      S_WAIT: begin
        wd_en = 1'b1;
        if (tx.tx_done) begin
          st_n = idx_q == len_q ? S_DONE : S_SEND;
          idx_n = idx_q == len_q ? idx_q : idx_q + 1'b1;
        end else if (wd_exp) begin
          err_n = 1'b1;
          busy_n = 1'b0;
          idx_n = '0;
          st_n = S_REARM;
        end
      end
      S_DONE: begin
        fd_n = 1'b1;
        cnt_n = cnt_en_in;
        busy_n = 1'b0;
        idx_n = '0;
        st_n = stream_en ? S_IDLE : S_REARM;
      end
      S_REARM: st_n = trig ? S_REARM : S_IDLE;
      default: st_n = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      st <= S_IDLE;
      for (int i = 0; i <= MAX_BYTES; i++) frm_q[i] <= '0;
      len_q <= '0;
      idx_q <= '0;
      tx.tx_data <= '0;
      tx.tx_start <= 1'b0;
      busy <= 1'b0;
      frame_done <= 1'b0;
      cnt_en <= 1'b0;
      tx_err <= 1'b0;
    end else begin
      st <= st_n;
      frm_q <= frm_n;
      len_q <= len_n;
      idx_q <= idx_n;
      tx.tx_data <= data_n;
      tx.tx_start <= start_n;
      busy <= busy_n;
      frame_done <= fd_n;
      cnt_en <= cnt_n;
      tx_err <= err_n;
    end
endmodule
